// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two data-memory requesters, the arbiter and dataMem.
// The arbiter takes the slave view; requesters and the memory model take the master view.
interface dmem_arbiter_if;
  logic        m0_req;
  logic        m0_we;
  logic [31:0] m0_addr;
  logic [7:0]  m0_wdata;
  logic        m0_ack;
  logic        m0_err;
  logic [7:0]  m0_rdata;

  logic        m1_req;
  logic        m1_we;
  logic [31:0] m1_addr;
  logic [7:0]  m1_wdata;
  logic        m1_ack;
  logic        m1_err;
  logic [7:0]  m1_rdata;

  logic        mem_we;
  logic [31:0] mem_a;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rd;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    input  mem_rd,
    output m0_ack, m0_err, m0_rdata,
    output m1_ack, m1_err, m1_rdata,
    output mem_we, mem_a, mem_wdata
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    output mem_rd,
    input  m0_ack, m0_err, m0_rdata,
    input  m1_ack, m1_err, m1_rdata,
    input  mem_we, mem_a, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of the byte-wide dataMem.
// Combinational grant, bounded bursts per owner, registered ack/err/rdata one cycle later.
module dmem_arbiter #(
  parameter int MAX_BURST = 4,
  parameter int ADDR_BITS = 12
) (
  input logic           clk,
  input logic           rst,
  dmem_arbiter_if.slave bus
);

  localparam int            CW      = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);

  logic          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          m0_ack_q, m0_ack_d;
  logic          m1_ack_q, m1_ack_d;
  logic          m0_err_q, m0_err_d;
  logic          m1_err_q, m1_err_d;
  logic [7:0]    m0_rdata_q, m0_rdata_d;
  logic [7:0]    m1_rdata_q, m1_rdata_d;

  logic          gnt_valid;
  logic          gnt_port;
  logic          gnt_we;
  logic [31:0]   gnt_addr;
  logic [7:0]    gnt_wdata;
  logic          in_range;
  logic [7:0]    rd_val;

  always_comb begin
    gnt_valid = bus.m0_req | bus.m1_req;
    gnt_port  = 1'b0;
    if (bus.m0_req && bus.m1_req) begin
      gnt_port = (cnt_q < MAX_CNT) ? last_q : ~last_q;
    end else if (bus.m1_req) begin
      gnt_port = 1'b1;
    end
    // With no request the mux rests on port 0, so idle mem_a/mem_wdata follow port 0.
    gnt_addr  = gnt_port ? bus.m1_addr  : bus.m0_addr;
    gnt_wdata = gnt_port ? bus.m1_wdata : bus.m0_wdata;
    gnt_we    = gnt_port ? bus.m1_we    : bus.m0_we;
    in_range  = ((gnt_addr >> ADDR_BITS) == 32'd0);
    rd_val    = (!gnt_we && in_range) ? bus.mem_rd : 8'h00;
  end

  assign bus.mem_a     = gnt_addr;
  assign bus.mem_wdata = gnt_wdata;
  assign bus.mem_we    = gnt_valid & gnt_we & in_range & ~rst;

  always_comb begin
    last_d     = last_q;
    cnt_d      = cnt_q;
    m0_ack_d   = 1'b0;
    m1_ack_d   = 1'b0;
    m0_err_d   = 1'b0;
    m1_err_d   = 1'b0;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    if (!gnt_valid) begin
      cnt_d = '0;
    end else begin
      if (gnt_port == last_q) begin
        cnt_d = (cnt_q == MAX_CNT) ? cnt_q : cnt_q + CW'(1);
      end else begin
        last_d = gnt_port;
        cnt_d  = CW'(1);
      end
      if (gnt_port) begin
        m1_ack_d   = 1'b1;
        m1_err_d   = ~in_range;
        m1_rdata_d = rd_val;
      end else begin
        m0_ack_d   = 1'b1;
        m0_err_d   = ~in_range;
        m0_rdata_d = rd_val;
      end
    end
  end

  // Owner resets to port 0 with an empty burst so port 0 takes the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q     <= 1'b0;
      cnt_q      <= '0;
      m0_ack_q   <= 1'b0;
      m1_ack_q   <= 1'b0;
      m0_err_q   <= 1'b0;
      m1_err_q   <= 1'b0;
      m0_rdata_q <= 8'h00;
      m1_rdata_q <= 8'h00;
    end else begin
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      m0_ack_q   <= m0_ack_d;
      m1_ack_q   <= m1_ack_d;
      m0_err_q   <= m0_err_d;
      m1_err_q   <= m1_err_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
    end
  end

  assign bus.m0_ack   = m0_ack_q;
  assign bus.m1_ack   = m1_ack_q;
  assign bus.m0_err   = m0_err_q;
  assign bus.m1_err   = m1_err_q;
  assign bus.m0_rdata = m0_rdata_q;
  assign bus.m1_rdata = m1_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 1024 x 8 dataMem behind it.
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  logic [8:0] pat9;
  logic [4:0] pat5;
  logic [7:0] mem [0:1023];

  dmem_arbiter_if bus();

  dmem_arbiter #(.MAX_BURST(4), .ADDR_BITS(12)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  assign bus.mem_rd = mem[bus.mem_a[11:2]];
  always @(posedge clk) if (bus.mem_we) mem[bus.mem_a[11:2]] <= bus.mem_wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive0(input logic r, input logic we, input logic [31:0] a, input logic [7:0] d);
    bus.m0_req = r; bus.m0_we = we; bus.m0_addr = a; bus.m0_wdata = d;
  endtask

  task automatic drive1(input logic r, input logic we, input logic [31:0] a, input logic [7:0] d);
    bus.m1_req = r; bus.m1_we = we; bus.m1_addr = a; bus.m1_wdata = d;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic mid;
    @(negedge clk);
  endtask

  initial begin
    // reset held two cycles with both ports requesting writes
    rst = 1'b1;
    drive0(1'b1, 1'b1, 32'h10, 8'hAA);
    drive1(1'b1, 1'b1, 32'h14, 8'hBB);
    for (int i = 0; i < 2; i++) begin
      mid;
      chk("rst_mem_we", bus.mem_we, 0);
      tick;
      chk("rst_ack0", bus.m0_ack, 0);
      chk("rst_ack1", bus.m1_ack, 0);
      chk("rst_err0", bus.m0_err, 0);
      chk("rst_err1", bus.m1_err, 0);
      chk("rst_rdata0", bus.m0_rdata, 0);
      chk("rst_rdata1", bus.m1_rdata, 0);
    end

    // contention from reset: port 0 first, bursts of four
    rst = 1'b0;
    drive0(1'b1, 1'b0, 32'h100, 8'h00);
    drive1(1'b1, 1'b0, 32'h200, 8'h00);
    pat9 = 9'b0_1111_0000;
    for (int i = 0; i < 9; i++) begin
      mid;
      chk("cont_mem_a", bus.mem_a, pat9[i] ? 32'h200 : 32'h100);
      chk("cont_mem_we", bus.mem_we, 0);
      tick;
      chk("cont_ack0", bus.m0_ack, !pat9[i]);
      chk("cont_ack1", bus.m1_ack, pat9[i]);
      chk("cont_one_ack", bus.m0_ack & bus.m1_ack, 0);
    end

    drive0(1'b0, 1'b0, 32'h0, 8'h00);
    drive1(1'b0, 1'b0, 32'h0, 8'h00);
    mid;
    chk("idle_mem_we", bus.mem_we, 0);
    tick;
    chk("idle_ack0", bus.m0_ack, 0);
    chk("idle_ack1", bus.m1_ack, 0);

    // single port write then read of the same address
    drive0(1'b1, 1'b1, 32'h10, 8'h5A);
    mid;
    chk("wr_mem_we", bus.mem_we, 1);
    chk("wr_mem_a", bus.mem_a, 32'h10);
    chk("wr_mem_wdata", bus.mem_wdata, 8'h5A);
    tick;
    chk("wr_ack0", bus.m0_ack, 1);
    chk("wr_err0", bus.m0_err, 0);
    chk("wr_rdata0", bus.m0_rdata, 8'h00);
    drive0(1'b1, 1'b0, 32'h10, 8'h00);
    tick;
    chk("rd_ack0", bus.m0_ack, 1);
    chk("rd_rdata0", bus.m0_rdata, 8'h5A);

    // third port-0 access, idle, then a tie: port 0 keeps a fresh burst of four
    tick;
    chk("rd2_rdata0", bus.m0_rdata, 8'h5A);
    drive0(1'b0, 1'b0, 32'h10, 8'h00);
    tick;
    chk("idle2_ack0", bus.m0_ack, 0);
    drive0(1'b1, 1'b0, 32'h10, 8'h00);
    drive1(1'b1, 1'b0, 32'h200, 8'h00);
    pat5 = 5'b1_0000;
    for (int i = 0; i < 5; i++) begin
      mid;
      chk("burst_mem_a", bus.mem_a, pat5[i] ? 32'h200 : 32'h10);
      tick;
      chk("burst_ack0", bus.m0_ack, !pat5[i]);
      chk("burst_ack1", bus.m1_ack, pat5[i]);
    end
    chk("burst_rdata0_hold", bus.m0_rdata, 8'h5A);

    // out-of-range write is acked with err and never reaches memory
    drive0(1'b0, 1'b0, 32'h0, 8'h00);
    drive1(1'b0, 1'b0, 32'h0, 8'h00);
    tick;
    drive0(1'b1, 1'b1, 32'h0, 8'h33);
    tick;
    drive0(1'b0, 1'b0, 32'h0, 8'h00);
    drive1(1'b1, 1'b1, 32'h1000, 8'hFF);
    mid;
    chk("oor_mem_we", bus.mem_we, 0);
    chk("oor_mem_a", bus.mem_a, 32'h1000);
    tick;
    chk("oor_ack1", bus.m1_ack, 1);
    chk("oor_err1", bus.m1_err, 1);
    chk("oor_ack0", bus.m0_ack, 0);
    drive1(1'b1, 1'b0, 32'h0, 8'h00);
    tick;
    chk("oor_keep_err1", bus.m1_err, 0);
    chk("oor_keep_rdata1", bus.m1_rdata, 8'h33);
    drive1(1'b1, 1'b0, 32'hFFC, 8'h00);
    tick;
    chk("top_ack1", bus.m1_ack, 1);
    chk("top_err1", bus.m1_err, 0);
    drive1(1'b1, 1'b0, 32'h2000, 8'h00);
    tick;
    chk("oor_rd_err1", bus.m1_err, 1);
    chk("oor_rd_rdata1", bus.m1_rdata, 8'h00);

    // low address bits ignored
    drive1(1'b0, 1'b0, 32'h0, 8'h00);
    drive0(1'b1, 1'b1, 32'h21, 8'h11);
    tick;
    drive0(1'b1, 1'b0, 32'h20, 8'h00);
    tick;
    chk("align_rdata0", bus.m0_rdata, 8'h11);
    drive0(1'b0, 1'b0, 32'h0, 8'h00);
    tick;
    chk("align_ack0_drop", bus.m0_ack, 0);

    // reset during a granted write: address shown, write suppressed, state cleared
    rst = 1'b1;
    drive0(1'b1, 1'b1, 32'h20, 8'h77);
    mid;
    chk("rstw_mem_we", bus.mem_we, 0);
    chk("rstw_mem_a", bus.mem_a, 32'h20);
    tick;
    chk("rstw_ack0", bus.m0_ack, 0);
    chk("rstw_rdata0", bus.m0_rdata, 8'h00);
    rst = 1'b0;
    drive0(1'b1, 1'b0, 32'h20, 8'h00);
    drive1(1'b1, 1'b0, 32'h200, 8'h00);
    mid;
    chk("rstw_tie_mem_a", bus.mem_a, 32'h20);
    tick;
    chk("rstw_tie_ack0", bus.m0_ack, 1);
    chk("rstw_tie_ack1", bus.m1_ack, 0);
    chk("rstw_tie_rdata0", bus.m0_rdata, 8'h11);

    drive0(1'b0, 1'b0, 32'h0, 8'h00);
    drive1(1'b0, 1'b0, 32'h0, 8'h00);
    tick;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
